priority_scan_encoder: RTL and testbench
========================================

// Module: priority_scan_encoder
//
// PURPOSE
//   Parametrised, sequential successor to the combinational 16-bit priority encoder.
//   - Accepts a WIDTH-bit request vector through a valid/ready handshake.
//   - Emits the index of every set bit, one per output handshake, in priority order.
//   - Clears each bit as it is emitted.
//   - Sits between request-collection logic and a single-index consumer in the CPU datapath.
//
// PARAMETERS
//   WIDTH      16  request vector width; legal range is 2..64
//   MSB_FIRST  1   1: highest set index is emitted first; 0: lowest set index is emitted first
//   IDX_W      $clog2(WIDTH)    localparam; width of out_idx
//   CNT_W      $clog2(WIDTH+1)  localparam; width of pending_cnt
//
// PORTS
//   clk          in   1      system clock; rising edge only
//   rst_n        in   1      asynchronous, active-low reset
//   flush        in   1      synchronous abort; discards all pending bits
//   din          in   WIDTH  request vector
//   din_valid    in   1      din is offered
//   din_ready    out  1      block can accept a vector (IDLE state)
//   out_idx      out  IDX_W  index of the current highest-priority pending bit
//   out_valid    out  1      out_idx is valid
//   out_ready    in   1      consumer accepts out_idx
//   out_last     out  1      current out_idx is the final pending bit
//   pending_cnt  out  CNT_W  population count of the pending register
//   busy         out  1      state == SCAN
//
// BEHAVIOUR
//   - Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
//   - Reset values:
//     - state = IDLE, pending = 0.
//     - din_ready = 1, out_valid = 0, out_idx = 0, out_last = 0, pending_cnt = 0, busy = 0.
//   - State machine: IDLE and SCAN only.
//     - IDLE:
//       - din_ready = 1.
//       - On din_valid and nonzero din: pending <= din, go to SCAN.
//       - On din_valid and din == 0: vector is accepted and dropped; stay in IDLE; no output is produced.
//     - SCAN:
//       - din_ready = 0; din_valid is ignored.
//       - On out_valid && out_ready: clear pending[out_idx].
//       - If out_last was 1 on that handshake, go to IDLE.
//   - Latency: a vector accepted at edge t gives out_valid = 1 in the cycle after t.
//     - One index is emitted per cycle while out_ready is held high.
//     - No bypass: after the final handshake, din_ready rises in the following cycle.
//   - Output derivation (combinational from registered pending/state; no din-to-output path):
//     - out_idx: priority-encode pending (MSB- or LSB-first per MSB_FIRST).
//     - out_idx = 0 when pending == 0; never X.
//     - out_last = out_valid && (pending_cnt == 1).
//     - out_valid = (state == SCAN) && !flush.
//   - Backpressure: while out_ready = 0, out_idx, out_last and pending are held stable.
//   - flush:
//     - Takes priority over every other event in the same cycle.
//     - pending <= 0 and state <= IDLE.
//     - out_valid is forced 0 in that cycle, so no transfer occurs.
//     - A din_valid in the same cycle is not accepted (din_ready = 0 while flush is high).
//   - Reset mid-scan: everything returns to reset values immediately; the partial scan is lost.
//   - Arithmetic:
//     - pending_cnt is the popcount of pending, CNT_W bits wide.
//     - For WIDTH not a power of two, out_idx never exceeds WIDTH-1.
//
// STRUCTURE
//   - Package pse_pkg holds:
//     - the state enum {IDLE, SCAN};
//     - a clog2 helper function;
//     - MSB_FIRST / LSB_FIRST mode constants.
//   - Sub-module prio_enc_n (combinational):
//     - Parameters: WIDTH, MSB_FIRST.
//     - Inputs: vec. Outputs: idx, any.
//     - Generalised replacement for the fixed 16-bit encoder.
//   - Top level holds the FSM, the pending register, the popcount and the handshake logic.
//
// TESTING
//   1. Reset, then WIDTH=16, MSB_FIRST=1; load din=16'h8421 with out_ready=1.
//      -> out_idx 15, 10, 5, 0 on four consecutive cycles.
//      -> out_last=1 only on idx 0.
//      -> din_ready=1 on the next cycle.
//   2. MSB_FIRST=0; load din=16'h8421.
//      -> out_idx 0, 5, 10, 15.
//      -> pending_cnt steps 4, 3, 2, 1, 0.
//   3. Load din=16'h0003; hold out_ready=0 for 3 cycles, then assert it.
//      -> out_idx stays 1 with out_valid=1 while stalled.
//      -> then out_idx 1, then 0 with out_last=1.
//   4. Load din=16'hFFFF; assert flush after 2 handshakes, with out_ready and din_valid also high.
//      -> no transfer in the flush cycle; pending_cnt=0 next cycle.
//      -> din_ready=1; the simultaneous din is not captured.
//   5. Load din=0 in IDLE.
//      -> out_valid never rises; din_ready stays 1; busy stays 0.
//   6. WIDTH=5; load 5'b10010, then pulse rst_n low mid-scan.
//      -> first out_idx is 4.
//      -> reset immediately clears out_valid and pending_cnt; din_ready=1.

Source files
------------

// File: rtl/pse_pkg.sv
// Shared types and helpers for the priority scan encoder.
package pse_pkg;

    // Scan controller states.
    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Emission order selectors for the MSB_FIRST parameter.
    localparam bit MSB_FIRST_MODE = 1'b1;
    localparam bit LSB_FIRST_MODE = 1'b0;

    // Ceiling log2; returns 0 for n <= 1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned p = 1; p < n; p = p << 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage : pse_pkg

// File: rtl/prio_enc_n.sv
// Parametrised combinational priority encoder.
// idx is the highest (MSB_FIRST=1) or lowest (MSB_FIRST=0) set bit of vec.
// idx is 0 when vec is all zeros; any flags a nonzero vec.
module prio_enc_n
    import pse_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter bit          MSB_FIRST = MSB_FIRST_MODE,
    localparam int unsigned IDX_W    = clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Last matching bit in scan order wins, so scan away from the priority end.
    always_comb begin
        idx = '0;
        any = |vec;
        if (MSB_FIRST) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (vec[i]) begin
                    idx = IDX_W'(i);
                end
            end
        end else begin
            for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
                if (vec[i]) begin
                    idx = IDX_W'(i);
                end
            end
        end
    end

endmodule : prio_enc_n

// File: rtl/priority_scan_encoder.sv
// Sequential priority scan encoder: accepts a request vector, then emits
// the index of each set bit in priority order, one per output handshake.
module priority_scan_encoder
    import pse_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter bit          MSB_FIRST = MSB_FIRST_MODE,
    localparam int unsigned IDX_W    = clog2(WIDTH),
    localparam int unsigned CNT_W    = clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [CNT_W-1:0] pending_cnt,
    output logic             busy
);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] pending_next;
    logic [WIDTH-1:0] clear_mask;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_any;
    logic [CNT_W-1:0] pop_cnt;

    // Priority encoder over the pending register.
    prio_enc_n #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_prio_enc (
        .vec (pending),
        .idx (enc_idx),
        .any (enc_any)
    );

    // State and pending register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pending <= '0;
        end else begin
            state   <= state_next;
            pending <= pending_next;
        end
    end

    // Population count of the pending register.
    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            pop_cnt = pop_cnt + CNT_W'(pending[i]);
        end
    end

    // One-hot mask of the bit currently being emitted.
    always_comb begin
        clear_mask = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (IDX_W'(i) == enc_idx) begin
                clear_mask[i] = 1'b1;
            end
        end
    end

    // Handshake outputs derived from registered state; flush masks both sides.
    always_comb begin
        din_ready   = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        out_idx     = enc_idx;
        pending_cnt = pop_cnt;
        busy        = (state == SCAN);
        din_ready   = (state == IDLE) && !flush;
        out_valid   = (state == SCAN) && enc_any && !flush;
        out_last    = out_valid && (pop_cnt == CNT_W'(1));
    end

    // Next-state and pending update; flush overrides everything.
    always_comb begin
        state_next   = state;
        pending_next = pending;
        if (flush) begin
            state_next   = IDLE;
            pending_next = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (din_valid && (din != '0)) begin
                        pending_next = din;
                        state_next   = SCAN;
                    end
                end
                SCAN: begin
                    if (out_valid && out_ready) begin
                        pending_next = pending & ~clear_mask;
                        if (out_last) begin
                            state_next = IDLE;
                        end
                    end
                end
                default: begin
                    state_next   = IDLE;
                    pending_next = '0;
                end
            endcase
        end
    end

endmodule : priority_scan_encoder

// File: tb/tb_priority_scan_encoder.sv
// Self-checking bench: three encoder instances (16/MSB, 16/LSB, 5/MSB)
// checked each cycle against a queue model of the pending indices.
module tb_priority_scan_encoder;

    logic        clk;
    logic        rst_n;

    logic [15:0] t_din  [3];
    logic        t_dv   [3];
    logic        t_ordy [3];
    logic        t_fl   [3];

    logic [3:0]  o_idx   [3];
    logic [4:0]  o_cnt   [3];
    logic        o_valid [3];
    logic        o_last  [3];
    logic        o_ready [3];
    logic        o_busy  [3];

    logic [3:0]  idx0, idx1;
    logic [2:0]  idx2;
    logic [4:0]  cnt0, cnt1;
    logic [2:0]  cnt2;
    logic        v0, v1, v2, l0, l1, l2, r0, r1, r2, b0, b1, b2;

    int          n_vec;
    int          n_err;
    int          q[$];
    int          cur_w;
    bit          cur_msb;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    priority_scan_encoder #(.WIDTH(16), .MSB_FIRST(1'b1)) u_msb16 (
        .clk(clk), .rst_n(rst_n), .flush(t_fl[0]), .din(t_din[0]),
        .din_valid(t_dv[0]), .din_ready(r0), .out_idx(idx0), .out_valid(v0),
        .out_ready(t_ordy[0]), .out_last(l0), .pending_cnt(cnt0), .busy(b0)
    );

    priority_scan_encoder #(.WIDTH(16), .MSB_FIRST(1'b0)) u_lsb16 (
        .clk(clk), .rst_n(rst_n), .flush(t_fl[1]), .din(t_din[1]),
        .din_valid(t_dv[1]), .din_ready(r1), .out_idx(idx1), .out_valid(v1),
        .out_ready(t_ordy[1]), .out_last(l1), .pending_cnt(cnt1), .busy(b1)
    );

    priority_scan_encoder #(.WIDTH(5), .MSB_FIRST(1'b1)) u_msb5 (
        .clk(clk), .rst_n(rst_n), .flush(t_fl[2]), .din(t_din[2][4:0]),
        .din_valid(t_dv[2]), .din_ready(r2), .out_idx(idx2), .out_valid(v2),
        .out_ready(t_ordy[2]), .out_last(l2), .pending_cnt(cnt2), .busy(b2)
    );

    assign o_idx[0]   = idx0;
    assign o_idx[1]   = idx1;
    assign o_idx[2]   = {1'b0, idx2};
    assign o_cnt[0]   = cnt0;
    assign o_cnt[1]   = cnt1;
    assign o_cnt[2]   = {2'b00, cnt2};
    assign o_valid[0] = v0;
    assign o_valid[1] = v1;
    assign o_valid[2] = v2;
    assign o_last[0]  = l0;
    assign o_last[1]  = l1;
    assign o_last[2]  = l2;
    assign o_ready[0] = r0;
    assign o_ready[1] = r1;
    assign o_ready[2] = r2;
    assign o_busy[0]  = b0;
    assign o_busy[1]  = b1;
    assign o_busy[2]  = b2;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Make instance sel the one under test; it must be idle.
    task automatic select(input int sel);
        cur_w   = (sel == 2) ? 5 : 16;
        cur_msb = (sel != 1);
        q.delete();
    endtask

    // Set bits of v in emission order.
    task automatic load_model(input logic [15:0] v);
        q.delete();
        if (cur_msb) begin
            for (int i = cur_w - 1; i >= 0; i--) if (v[i]) q.push_back(i);
        end else begin
            for (int i = 0; i < cur_w; i++) if (v[i]) q.push_back(i);
        end
    endtask

    task automatic chk_reset(input int sel);
        chk("rst_out_valid", 16'(o_valid[sel]), 16'd0);
        chk("rst_out_idx",   16'(o_idx[sel]),   16'd0);
        chk("rst_out_last",  16'(o_last[sel]),  16'd0);
        chk("rst_pend_cnt",  16'(o_cnt[sel]),   16'd0);
        chk("rst_din_ready", 16'(o_ready[sel]), 16'd1);
        chk("rst_busy",      16'(o_busy[sel]),  16'd0);
    endtask

    // One clock: drive at negedge, check just after, advance model for the next posedge.
    task automatic cycle(input int sel, input logic dv, input logic [15:0] d,
                         input logic ordy, input logic fl);
        logic [15:0] dm;
        bit          scan;
        int          exp_idx;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            t_dv[k] = 1'b0; t_din[k] = '0; t_ordy[k] = 1'b0; t_fl[k] = 1'b0;
        end
        t_dv[sel] = dv; t_din[sel] = d; t_ordy[sel] = ordy; t_fl[sel] = fl;
        #1;
        scan    = (q.size() != 0);
        exp_idx = scan ? q[0] : 0;
        chk("out_valid",   16'(o_valid[sel]), 16'(scan && !fl));
        chk("out_idx",     16'(o_idx[sel]),   16'(exp_idx));
        chk("out_last",    16'(o_last[sel]),  16'(scan && !fl && q.size() == 1));
        chk("pending_cnt", 16'(o_cnt[sel]),   16'(q.size()));
        chk("din_ready",   16'(o_ready[sel]), 16'(!scan && !fl));
        chk("busy",        16'(o_busy[sel]),  16'(scan));
        dm = d & 16'((32'h1 << cur_w) - 1);
        if (fl) begin
            q.delete();
        end else if (!scan) begin
            if (dv && dm != 16'd0) load_model(dm);
        end else if (ordy) begin
            void'(q.pop_front());
        end
    endtask

    initial begin
        logic [15:0] rd;
        logic        rdv, rordy, rfl;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            t_dv[k] = 1'b0; t_din[k] = '0; t_ordy[k] = 1'b0; t_fl[k] = 1'b0;
        end
        repeat (2) @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) chk_reset(k);
        @(negedge clk);
        rst_n = 1'b1;

        // MSB-first scan of 16'h8421: 15, 10, 5, 0 then ready again.
        select(0);
        cycle(0, 1'b1, 16'h8421, 1'b1, 1'b0);
        repeat (5) cycle(0, 1'b0, 16'h0000, 1'b1, 1'b0);

        // LSB-first scan of the same vector.
        select(1);
        cycle(1, 1'b1, 16'h8421, 1'b1, 1'b0);
        repeat (5) cycle(1, 1'b0, 16'h0000, 1'b1, 1'b0);

        // Backpressure on 16'h0003.
        select(0);
        cycle(0, 1'b1, 16'h0003, 1'b0, 1'b0);
        repeat (3) cycle(0, 1'b0, 16'h0000, 1'b0, 1'b0);
        repeat (3) cycle(0, 1'b0, 16'h0000, 1'b1, 1'b0);

        // Flush after two handshakes, with din_valid and out_ready also high.
        cycle(0, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        repeat (2) cycle(0, 1'b0, 16'h0000, 1'b1, 1'b0);
        cycle(0, 1'b1, 16'h00F0, 1'b1, 1'b1);
        repeat (2) cycle(0, 1'b0, 16'h0000, 1'b1, 1'b0);

        // Zero vector is dropped in IDLE.
        repeat (3) cycle(0, 1'b1, 16'h0000, 1'b1, 1'b0);

        // Non-power-of-two width, then asynchronous reset mid-scan.
        select(2);
        cycle(2, 1'b1, 16'h0012, 1'b1, 1'b0);
        cycle(2, 1'b0, 16'h0000, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk("pre_rst_cnt", 16'(o_cnt[2]), 16'(q.size()));
        #1;
        rst_n = 1'b0;
        #1;
        q.delete();
        chk_reset(2);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic on each instance, drained before switching.
        for (int s = 0; s < 3; s++) begin
            select(s);
            repeat (60) begin
                rd    = 16'($urandom);
                if ($urandom_range(0, 7) == 0) rd = 16'd0;
                rdv   = ($urandom_range(0, 3) != 0);
                rordy = ($urandom_range(0, 3) != 0);
                rfl   = ($urandom_range(0, 15) == 0);
                cycle(s, rdv, rd, rordy, rfl);
            end
            repeat (cur_w + 2) cycle(s, 1'b0, 16'h0000, 1'b1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_priority_scan_encoder
